// File: rtl/gppm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : gppm_sequencer
// Purpose  : Instruction sequencer for the GPPM datapath (register file +
//            ALU). Holds a loadable program memory and runs each instruction
//            as a FETCH/EXEC pair. In EXEC it drives GPPM's register
//            addresses, write enable, write-data source, ALU function and
//            immediate. It branches on a zero flag latched from GPPM's
//            isZero.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            start/busy/done/error - run handshake (done/error: 1-cycle pulses)
//            prog_we/addr/data   - program load port (honoured only in IDLE)
//            raddr1/raddr2/waddr/wen/wdsrc/func/constant - GPPM control port
//            isZero              - GPPM ALU zero flag
//            zflag               - latched zero flag
// Revision : 1.0 - initial release
// ============================================================================
module gppm_sequencer #(
    parameter int PC_W      = 5,
    parameter int MAX_INSTR = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    input  logic            prog_we,
    input  logic [PC_W-1:0] prog_addr,
    input  logic [51:0]     prog_data,
    output logic [3:0]      raddr1,
    output logic [3:0]      raddr2,
    output logic [3:0]      waddr,
    output logic            wen,
    output logic            wdsrc,
    output logic [3:0]      func,
    output logic [31:0]     constant,
    input  logic            isZero,
    output logic            zflag
);

    localparam int c_depth = 1 << PC_W;
    localparam int c_cnt_w = $clog2(MAX_INSTR + 1);
    localparam logic [c_cnt_w-1:0] c_max_cnt = c_cnt_w'(MAX_INSTR);

    localparam logic [3:0] c_op_ldi  = 4'd1;
    localparam logic [3:0] c_op_alu  = 4'd2;
    localparam logic [3:0] c_op_cmp  = 4'd3;
    localparam logic [3:0] c_op_jmp  = 4'd4;
    localparam logic [3:0] c_op_bz   = 4'd5;
    localparam logic [3:0] c_op_bnz  = 4'd6;
    localparam logic [3:0] c_op_halt = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [51:0]        ir_q, ir_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               zflag_q, zflag_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    // Program memory deliberately has no reset.
    logic [51:0]        prog_mem [c_depth];

    logic [3:0]         w_op;
    logic [c_cnt_w-1:0] w_cnt_inc;
    logic [PC_W-1:0]    w_target;

    assign w_op      = ir_q[51:48];
    assign w_cnt_inc = cnt_q + c_cnt_w'(1);
    assign w_target  = ir_q[PC_W-1:0];

    assign busy  = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign done  = done_q;
    assign error = error_q;
    assign zflag = zflag_q;

    always_ff @(posedge clk) begin
        if (prog_we && (state_q == S_IDLE)) begin
            prog_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            cnt_q   <= '0;
            zflag_q <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            zflag_q <= zflag_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        cnt_d    = cnt_q;
        zflag_d  = zflag_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        raddr1   = '0;
        raddr2   = '0;
        waddr    = '0;
        wen      = 1'b0;
        wdsrc    = 1'b0;
        func     = '0;
        constant = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end

            S_FETCH: begin
                ir_d    = prog_mem[pc_q];
                state_d = S_EXEC;
            end

            S_EXEC: begin
                waddr  = ir_q[47:44];
                raddr1 = ir_q[43:40];
                raddr2 = ir_q[39:36];
                func   = ir_q[35:32];
                cnt_d  = w_cnt_inc;
                // Natural PC_W-bit overflow gives the modulo-depth wrap.
                pc_d   = pc_q + PC_W'(1);

                case (w_op)
                    c_op_ldi: begin
                        wen      = 1'b1;
                        constant = ir_q[31:0];
                    end
                    c_op_alu: begin
                        wen     = 1'b1;
                        wdsrc   = 1'b1;
                        zflag_d = isZero;
                    end
                    c_op_cmp: zflag_d = isZero;
                    c_op_jmp: pc_d = w_target;
                    c_op_bz:  if (zflag_q)  pc_d = w_target;
                    c_op_bnz: if (!zflag_q) pc_d = w_target;
                    default: ;
                endcase

                // Budget exhaustion wins over HALT on the same instruction.
                if (w_cnt_inc == c_max_cnt) begin
                    state_d = S_IDLE;
                    error_d = 1'b1;
                end else if (w_op == c_op_halt) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_gppm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_gppm_sequencer
// Purpose  : Self-checking bench for gppm_sequencer. Instance u_dut uses a
//            10-instruction budget; u_dut_b uses a 40-instruction budget for
//            the full-memory wrap run. Both instances share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gppm_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, prog_we, iz;
    logic [4:0]  prog_addr;
    logic [51:0] prog_data;

    logic        busy, done, error, wen, wdsrc, zflag;
    logic [3:0]  raddr1, raddr2, waddr, func;
    logic [31:0] constant;

    logic        busy_b, done_b, error_b, wen_b, wdsrc_b, zflag_b;
    logic [3:0]  raddr1_b, raddr2_b, waddr_b, func_b;
    logic [31:0] constant_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gppm_sequencer #(.PC_W(5), .MAX_INSTR(10)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .error(error), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .raddr1(raddr1), .raddr2(raddr2),
        .waddr(waddr), .wen(wen), .wdsrc(wdsrc), .func(func),
        .constant(constant), .isZero(iz), .zflag(zflag)
    );

    gppm_sequencer #(.PC_W(5), .MAX_INSTR(40)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .busy(busy_b), .done(done_b),
        .error(error_b), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .raddr1(raddr1_b), .raddr2(raddr2_b),
        .waddr(waddr_b), .wen(wen_b), .wdsrc(wdsrc_b), .func(func_b),
        .constant(constant_b), .isZero(iz), .zflag(zflag_b)
    );

    typedef struct {
        logic [51:0] instr;
        logic        iz;
        logic        wen;
        logic        wdsrc;
        logic [3:0]  wa;
        logic [3:0]  r1;
        logic [3:0]  r2;
        logic [3:0]  f;
        logic [31:0] c;
        logic        zf;
    } vec_t;

    vec_t vecs [8];

    function automatic logic [51:0] mk(input logic [3:0] op, input logic [3:0] wa,
                                       input logic [3:0] r1, input logic [3:0] r2,
                                       input logic [3:0] f, input logic [31:0] c);
        return {op, wa, r1, r2, f, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load(input int addr, input logic [51:0] data);
        prog_we   = 1'b1;
        prog_addr = 5'(addr);
        prog_data = data;
        tick();
        prog_we   = 1'b0;
    endtask

    // Leaves the bench sampling cycle 1 (the first FETCH) after the start cycle.
    task automatic start_run();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Follows u_dut until done or error, counting cycles from the start cycle.
    task automatic wait_end(input int cyc0, input int budget, output int cyc,
                            output bit got_done, output bit got_err,
                            output bit got_wr, output logic [3:0] wa);
        cyc = cyc0; got_done = 0; got_err = 0; got_wr = 0; wa = '0;
        while ((cyc <= budget) && !got_done && !got_err) begin
            if (wen && !got_wr) begin
                got_wr = 1;
                wa     = waddr;
            end
            if (done)       got_done = 1;
            else if (error) got_err  = 1;
            else begin
                tick();
                cyc++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int          cyc;
        bit          gd, ge, gw;
        logic [3:0]  wa;
        logic [51:0] halt_w;
        logic [4:0]  a5;
        logic [3:0]  op;

        halt_w = mk(4'd7, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0);
        //                 instr                                             iz wen ws wa    r1    r2    f     c             zf
        vecs[0] = '{mk(4'd1, 4'd3, 4'd5, 4'd6, 4'd7, 32'hAA),            0, 1, 0, 4'h3, 4'h5, 4'h6, 4'h7, 32'hAA,       0};
        vecs[1] = '{mk(4'd2, 4'd1, 4'd2, 4'd0, 4'd4, 32'h1234),          1, 1, 1, 4'h1, 4'h2, 4'h0, 4'h4, 32'h0,        1};
        vecs[2] = '{mk(4'd3, 4'd9, 4'hA, 4'hB, 4'hC, 32'h55),            0, 0, 0, 4'h9, 4'hA, 4'hB, 4'hC, 32'h0,        0};
        vecs[3] = '{mk(4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 32'hFFFF),          1, 0, 0, 4'h2, 4'h3, 4'h4, 4'h5, 32'h0,        0};
        vecs[4] = '{mk(4'd3, 4'hF, 4'hE, 4'hD, 4'h3, 32'h0),             1, 0, 0, 4'hF, 4'hE, 4'hD, 4'h3, 32'h0,        1};
        vecs[5] = '{mk(4'd12, 4'd1, 4'd1, 4'd1, 4'd1, 32'hDEAD),         0, 0, 0, 4'h1, 4'h1, 4'h1, 4'h1, 32'h0,        1};
        vecs[6] = '{mk(4'd1, 4'd0, 4'd0, 4'd0, 4'd0, 32'hFFFF_FFFF),     0, 1, 0, 4'h0, 4'h0, 4'h0, 4'h0, 32'hFFFF_FFFF, 1};
        vecs[7] = '{mk(4'd2, 4'd8, 4'd7, 4'd6, 4'd9, 32'h0),             0, 1, 1, 4'h8, 4'h7, 4'h6, 4'h9, 32'h0,        0};

        rst = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; iz = 1'b0;
        repeat (3) tick();
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset error", error, 0);
        chk("reset wen", wen, 0);
        chk("reset constant", constant, 0);
        chk("reset zflag", zflag, 0);
        rst = 1'b0;
        tick();

        // Single instruction followed by HALT, one table entry per run.
        for (int i = 0; i < 8; i++) begin
            load(0, vecs[i].instr);
            load(1, halt_w);
            iz = vecs[i].iz;
            start_run();
            chk($sformatf("v%0d fetch busy", i), busy, 1);
            chk($sformatf("v%0d fetch wen", i), wen, 0);
            tick();
            chk($sformatf("v%0d wen", i), wen, vecs[i].wen);
            chk($sformatf("v%0d wdsrc", i), wdsrc, vecs[i].wdsrc);
            chk($sformatf("v%0d waddr", i), waddr, vecs[i].wa);
            chk($sformatf("v%0d raddr1", i), raddr1, vecs[i].r1);
            chk($sformatf("v%0d raddr2", i), raddr2, vecs[i].r2);
            chk($sformatf("v%0d func", i), func, vecs[i].f);
            chk($sformatf("v%0d constant", i), constant, vecs[i].c);
            tick();
            tick();
            chk($sformatf("v%0d done early", i), done, 0);
            tick();
            chk($sformatf("v%0d done at 5", i), done, 1);
            chk($sformatf("v%0d busy after", i), busy, 0);
            chk($sformatf("v%0d zflag", i), zflag, vecs[i].zf);
            tick();
            chk($sformatf("v%0d done pulse", i), done, 0);
        end

        // Write and start in the same IDLE cycle: the new word is executed.
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = mk(4'd1, 4'd5, 4'd0, 4'd0, 4'd0, 32'h77);
        start = 1'b1;
        tick();
        prog_we = 1'b0; start = 1'b0;
        tick();
        chk("we+start waddr", waddr, 4'd5);
        chk("we+start constant", constant, 32'h77);
        wait_end(2, 20, cyc, gd, ge, gw, wa);
        chk("we+start done cycle", cyc, 5);

        // Branch program.
        load(0, mk(4'd3, 4'd0, 4'd1, 4'd2, 4'd0, 32'd0));
        load(1, mk(4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 32'd5));
        load(2, mk(4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 32'd1));
        load(3, halt_w);
        load(4, halt_w);
        load(5, mk(4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 32'd2));
        load(6, halt_w);
        iz = 1'b1;
        start_run();
        wait_end(1, 30, cyc, gd, ge, gw, wa);
        chk("bz taken waddr", wa, 4'd2);
        chk("bz taken done cycle", gd ? cyc : -1, 9);
        iz = 1'b0;
        start_run();
        wait_end(1, 30, cyc, gd, ge, gw, wa);
        chk("bz fall waddr", wa, 4'd1);
        chk("bz fall done cycle", gd ? cyc : -1, 9);
        load(1, mk(4'd6, 4'd0, 4'd0, 4'd0, 4'd0, 32'd5));
        start_run();
        wait_end(1, 30, cyc, gd, ge, gw, wa);
        chk("bnz taken waddr", wa, 4'd2);

        // Endless JMP 0 loop hits the 10-instruction budget.
        load(0, mk(4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 32'd0));
        start_run();
        tick();
        tick();
        prog_we = 1'b1; prog_addr = 5'd0; prog_data = halt_w;
        tick();
        prog_we = 1'b0;
        wait_end(4, 40, cyc, gd, ge, gw, wa);
        chk("loop error seen", ge, 1);
        chk("loop no done", gd, 0);
        chk("loop error cycle", cyc, 21);
        tick();
        chk("loop error pulse", error, 0);
        chk("loop busy after", busy, 0);
        start_run();
        wait_end(1, 40, cyc, gd, ge, gw, wa);
        chk("rerun error seen", ge, 1);
        chk("rerun no done", gd, 0);
        chk("rerun error cycle", cyc, 21);

        // Reset during an LDI EXEC.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        load(0, mk(4'd1, 4'd3, 4'd0, 4'd0, 4'd0, 32'hAA));
        load(1, halt_w);
        start_run();
        tick();
        chk("pre-rst wen", wen, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst wen", wen, 0);
        chk("rst waddr", waddr, 0);
        chk("rst constant", constant, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        start_run();
        tick();
        chk("restart waddr", waddr, 4'd3);
        chk("restart constant", constant, 32'hAA);
        wait_end(2, 20, cyc, gd, ge, gw, wa);
        chk("restart done cycle", gd ? cyc : -1, 5);

        // Full memory of NOP variants on the 40-instruction instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            a5 = 5'(i);
            op = a5[0] ? (4'd8 + {1'b0, a5[2:0]}) : 4'd0;
            load(i, mk(op, a5[3:0], {3'b000, a5[4]}, 4'd0, 4'd0, 32'h1000 + 32'(i)));
        end
        start_run();
        for (int k = 0; k < 40; k++) begin
            tick();
            chk($sformatf("nop pc k=%0d", k), {raddr1_b[0], waddr_b}, 32'(k % 32));
            chk($sformatf("nop wen k=%0d", k), wen_b, 0);
            chk($sformatf("nop constant k=%0d", k), constant_b, 0);
            chk($sformatf("nop error k=%0d", k), error_b, 0);
            tick();
        end
        chk("nop error after 40", error_b, 1);
        chk("nop no done", done_b, 0);
        chk("nop busy after", busy_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
